// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time onto the data_memory byte/halfword/word port.
// Build option LSU_MISALIGNED_EN: split misaligned accesses into byte accesses instead of rejecting them.
module load_store_unit #(
    parameter int DMEM_DATA_WIDTH = 32,
    parameter int DMEM_ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_funct3,
    input  logic [31:0]                req_addr,
    input  logic [DMEM_DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    output logic [DMEM_DATA_WIDTH-1:0] rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_wr_en,
    output logic [1:0]                 mem_rw_mode,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DMEM_DATA_WIDTH-1:0] mem_w_data,
    input  logic [DMEM_DATA_WIDTH-1:0] mem_r_data
);

    localparam int DW = DMEM_DATA_WIDTH;
    localparam int AW = DMEM_ADDR_WIDTH;
    localparam logic [1:0]  MODE_BYTE = 2'b00;
    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

`ifdef LSU_MISALIGNED_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, SPLIT = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
`endif

    state_t     state_reg;
    logic       we_reg;
    logic [2:0] funct3_reg;

    logic [1:0] size_m1;
    logic       f3_illegal;
    logic       out_of_range;
    logic       misaligned;
    logic       misaligned_err;

    assign req_ready = (state_reg == IDLE);

    // Request decode; only meaningful in IDLE when the request is accepted.
    always_comb begin
        size_m1 = 2'd0;
        case (req_funct3[1:0])
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
        f3_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110)
                     || (req_we && req_funct3[2]);
        // Upper address bits must be clear and the last byte must not pass the top of memory.
        out_of_range = (|req_addr[31:AW])
                       || (({1'b0, req_addr[AW-1:0]} + {{(AW-1){1'b0}}, size_m1}) > LAST_ADDR);
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    function automatic logic [DW-1:0] extend(input logic [2:0] f3, input logic [DW-1:0] raw);
        case (f3)
            3'b000:  extend = {{(DW-8){raw[7]}}, raw[7:0]};
            3'b001:  extend = {{(DW-16){raw[15]}}, raw[15:0]};
            3'b100:  extend = {{(DW-8){1'b0}}, raw[7:0]};
            3'b101:  extend = {{(DW-16){1'b0}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    function automatic logic [DW-1:0] store_lanes(input logic [1:0] mode, input logic [DW-1:0] wdata);
        case (mode)
            2'b00:   store_lanes = {{(DW-8){1'b0}}, wdata[7:0]};
            2'b01:   store_lanes = {{(DW-16){1'b0}}, wdata[15:0]};
            default: store_lanes = wdata;
        endcase
    endfunction

`ifdef LSU_MISALIGNED_EN
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic [DW-1:0] buf_reg;
    logic [DW-1:0] split_word;
    logic [1:0]    byte_idx_reg;
    logic [1:0]    last_idx_reg;
    logic [1:0]    next_idx;

    assign next_idx = byte_idx_reg + 2'd1;

    // Load buffer with the byte arriving this cycle merged into its lane.
    generate
        for (genvar gi = 0; gi < DW / 8; gi++) begin : g_split_lane
            assign split_word[gi*8 +: 8] = (int'(byte_idx_reg) == gi) ? mem_r_data[7:0]
                                                                       : buf_reg[gi*8 +: 8];
        end
    endgenerate

    assign misaligned_err = 1'b0;
`else
    assign misaligned_err = misaligned;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'd0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            mem_wr_en    <= 1'b0;
            mem_rw_mode  <= MODE_BYTE;
            mem_addr     <= '0;
            mem_w_data   <= '0;
`ifdef LSU_MISALIGNED_EN
            addr_reg     <= '0;
            wdata_reg    <= '0;
            buf_reg      <= '0;
            byte_idx_reg <= 2'd0;
            last_idx_reg <= 2'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
`ifdef LSU_MISALIGNED_EN
                        addr_reg   <= req_addr[AW-1:0];
                        wdata_reg  <= req_wdata;
`endif
                        if (f3_illegal || out_of_range || misaligned_err) begin
                            state_reg <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
`ifdef LSU_MISALIGNED_EN
                        else if (misaligned) begin
                            state_reg    <= SPLIT;
                            byte_idx_reg <= 2'd0;
                            last_idx_reg <= size_m1;
                            buf_reg      <= '0;
                            mem_wr_en    <= req_we;
                            mem_rw_mode  <= MODE_BYTE;
                            mem_addr     <= req_addr[AW-1:0];
                            mem_w_data   <= {{(DW-8){1'b0}}, req_wdata[7:0]};
                        end
`endif
                        else begin
                            state_reg   <= ACCESS;
                            mem_wr_en   <= req_we;
                            mem_rw_mode <= req_funct3[1:0];
                            mem_addr    <= req_addr[AW-1:0];
                            mem_w_data  <= store_lanes(req_funct3[1:0], req_wdata);
                        end
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                    mem_wr_en <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_reg ? '0 : extend(funct3_reg, mem_r_data);
                end
`ifdef LSU_MISALIGNED_EN
                SPLIT: begin
                    buf_reg <= split_word;
                    if (byte_idx_reg == last_idx_reg) begin
                        state_reg <= RESP;
                        mem_wr_en <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we_reg ? '0 : extend(funct3_reg, split_word);
                    end else begin
                        byte_idx_reg <= next_idx;
                        mem_addr     <= addr_reg + {{(AW-2){1'b0}}, next_idx};
                        mem_w_data   <= {{(DW-8){1'b0}}, wdata_reg[8*next_idx +: 8]};
                    end
                end
`endif
                RESP: begin
                    state_reg <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    mem_wr_en <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, transaction-level reference model, random and directed requests.
// Follows the DUT build: define LSU_MISALIGNED_EN for both to exercise the split path.
module tb_load_store_unit;

    localparam int AW        = 12;
    localparam int MEM_BYTES = 1 << AW;
`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_wr_en;
    logic [1:0]    mem_rw_mode;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_w_data;
    logic [31:0]   mem_r_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] dmem    [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       mem_cleared = 1'b0;

    load_store_unit #(
        .DMEM_DATA_WIDTH(32),
        .DMEM_ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_wr_en  (mem_wr_en),
        .mem_rw_mode(mem_rw_mode),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    always #5 clk = ~clk;

    function automatic int wrap(input logic [AW-1:0] a, input int off);
        return (int'(a) + off) % MEM_BYTES;
    endfunction

    // data_memory stand-in: asynchronous zero-extended read, synchronous write.
    always_comb begin
        mem_r_data = 32'd0;
        case (mem_rw_mode)
            2'b00:   mem_r_data = {24'd0, dmem[mem_addr]};
            2'b01:   mem_r_data = {16'd0, dmem[wrap(mem_addr, 1)], dmem[mem_addr]};
            default: mem_r_data = {dmem[wrap(mem_addr, 3)], dmem[wrap(mem_addr, 2)],
                                   dmem[wrap(mem_addr, 1)], dmem[mem_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= 8'd0;
            mem_cleared <= 1'b1;
        end else if (mem_wr_en) begin
            dmem[mem_addr] <= mem_w_data[7:0];
            if (mem_rw_mode != 2'b00) dmem[wrap(mem_addr, 1)] <= mem_w_data[15:8];
            if (mem_rw_mode == 2'b10) begin
                dmem[wrap(mem_addr, 2)] <= mem_w_data[23:16];
                dmem[wrap(mem_addr, 3)] <= mem_w_data[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request end to end: model the expected outcome, drive it, watch the memory port, check the response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] got);
        int          size;
        bit          illegal, oor, mis, err;
        int          exp_lat, exp_wr, lat, wr_seen, n;
        longint      last;
        logic [31:0] raw, exp_data, mask;
        int          base;

        case (f3[1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            default: size = 4;
        endcase
        illegal  = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (we && f3[2]);
        last     = longint'({32'd0, addr}) + longint'(size) - 1;
        oor      = (last >= longint'(MEM_BYTES));
        mis      = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        err      = illegal || oor || (mis && !MIS_EN);
        exp_lat  = err ? 1 : (mis ? size + 1 : 2);
        exp_wr   = (err || !we) ? 0 : (mis ? size : 1);
        mask     = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        base     = int'(addr[AW-1:0]);
        exp_data = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
            end else begin
                raw = 32'd0;
                for (int i = 0; i < size; i++) raw[8*i +: 8] = ref_mem[base + i];
                case (f3)
                    3'b000:  exp_data = {{24{raw[7]}}, raw[7:0]};
                    3'b001:  exp_data = {{16{raw[15]}}, raw[15:0]};
                    3'b100:  exp_data = {24'd0, raw[7:0]};
                    3'b101:  exp_data = {16'd0, raw[15:0]};
                    default: exp_data = raw;
                endcase
            end
        end

        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat     = 1;
        wr_seen = 0;
        while (!rsp_valid && lat < 20) begin
            if (mem_wr_en) begin
                if (mis) begin
                    check_eq({tag, "_wr_mode"}, {30'd0, mem_rw_mode}, 32'd0);
                    check_eq({tag, "_wr_addr"}, {{(32-AW){1'b0}}, mem_addr}, 32'(base + wr_seen));
                    if (wr_seen < 4)
                        check_eq({tag, "_wr_data"}, mem_w_data, {24'd0, wdata[8*wr_seen +: 8]});
                end else begin
                    check_eq({tag, "_wr_mode"}, {30'd0, mem_rw_mode}, {30'd0, f3[1:0]});
                    check_eq({tag, "_wr_addr"}, {{(32-AW){1'b0}}, mem_addr}, 32'(base));
                    check_eq({tag, "_wr_data"}, mem_w_data & mask, wdata & mask);
                end
                wr_seen++;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (mem_wr_en) wr_seen++;
        got = rsp_rdata;
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_writes"}, wr_seen, exp_wr);
        check_eq({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
        check_eq({tag, "_rdata"}, rsp_rdata, exp_data);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        $display("txn %s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> err=%0d rdata=0x%08h lat=%0d",
                 tag, we, f3, addr, wdata, rsp_err, got, lat);
    endtask

    // Reset during a store in flight: no response, write enable drops on the reset edge.
    task automatic reset_mid_op();
        logic [31:0] addr;
        int          base;
        addr = MIS_EN ? 32'h13 : 32'h40;
        base = int'(addr);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = addr;
        req_wdata  = 32'h1122_3344;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (MIS_EN) begin
            @(posedge clk); #1;
            check_eq("rst_split_k1_addr", {{(32-AW){1'b0}}, mem_addr}, 32'h14);
            // The reset edge still commits the byte whose write was pending.
            ref_mem[base]     = 8'h44;
            ref_mem[base + 1] = 8'h33;
        end else begin
            for (int i = 0; i < 4; i++) ref_mem[base + i] = req_wdata[8*i +: 8];
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_wr_en_drop", {31'd0, mem_wr_en}, 32'd0);
        check_eq("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_eq("rst_release_no_rsp", {31'd0, rsp_valid}, 32'd0);
            check_eq("rst_release_ready", {31'd0, req_ready}, 32'd1);
        end
        check_eq("rst_first_byte", {24'd0, dmem[base]}, 32'h44);
        $display("txn reset_mid_op addr=0x%08h first_byte=0x%02h", addr, dmem[base]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_eq("reset_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
        check_eq("reset_mem_w_data", mem_w_data, 32'd0);
        check_eq("reset_mem_rw_mode", {30'd0, mem_rw_mode}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("ready_after_reset", {31'd0, req_ready}, 32'd1);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10", got);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, "lw_10", got);
        check_eq("lw_10_value", got, 32'hDEAD_BEEF);

        do_req(1'b1, 3'b000, 32'h20, 32'h0000_0080, "sb_20", got);
        do_req(1'b0, 3'b000, 32'h20, 32'd0, "lb_20", got);
        check_eq("lb_20_value", got, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h20, 32'd0, "lbu_20", got);
        check_eq("lbu_20_value", got, 32'h0000_0080);
        do_req(1'b1, 3'b000, 32'h20, 32'h0000_0000, "sb_20_lo", got);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_0080, "sb_21_hi", got);
        do_req(1'b0, 3'b001, 32'h20, 32'd0, "lh_20", got);
        check_eq("lh_20_value", got, 32'hFFFF_8000);
        do_req(1'b0, 3'b101, 32'h20, 32'd0, "lhu_20", got);
        check_eq("lhu_20_value", got, 32'h0000_8000);

        do_req(1'b1, 3'b010, 32'h13, 32'h1122_3344, "sw_13", got);
        do_req(1'b0, 3'b010, 32'h13, 32'd0, "lw_13", got);
        check_eq("lw_13_value", got, MIS_EN ? 32'h1122_3344 : 32'd0);
        do_req(1'b0, 3'b001, 32'h21, 32'd0, "lh_21", got);

        do_req(1'b0, 3'b010, 32'hFFE, 32'd0, "lw_ffe", got);
        check_eq("lw_ffe_value", got, 32'd0);
        do_req(1'b0, 3'b010, 32'h1000, 32'd0, "lw_1000", got);
        do_req(1'b1, 3'b100, 32'h30, 32'h0000_00AA, "sb_f3_100", got);
        do_req(1'b0, 3'b011, 32'h30, 32'd0, "ld_f3_011", got);
        do_req(1'b1, 3'b010, 32'hFFC, 32'hCAFE_F00D, "sw_ffc", got);
        do_req(1'b0, 3'b010, 32'hFFC, 32'd0, "lw_ffc", got);
        do_req(1'b0, 3'b000, 32'hFFF, 32'd0, "lb_fff", got);

        addr = MIS_EN ? 32'h13 : 32'h40;
        do_req(1'b1, 3'b000, addr, 32'd0, "sb_clear", got);
        reset_mid_op();
        do_req(1'b0, 3'b010, addr, 32'd0, "lw_after_rst", got);

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0:       addr = 32'h1000 + 32'($urandom_range(0, 8));
                1:       addr = $urandom;
                2, 3:    addr = 32'(MEM_BYTES - $urandom_range(1, 8));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
                   $sformatf("rnd%0d", t), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing stage between the execute stage and `data_memory`. It accepts one load or store per handshake and range-checks the address. It drives the memory's byte/halfword/word port, then returns a sign- or zero-extended load result or a store completion as a one-cycle response pulse. Misaligned accesses are either split into byte accesses or rejected, selected at compile time, so the memory only ever sees legal accesses.

## Interface
- `DMEM_DATA_WIDTH`, 32: data width; only 32 is supported.
- `DMEM_ADDR_WIDTH`, 12: byte-address width of the data memory.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low (0 = reset, sampled on `clk` rising edge).
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: encodings are LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low bytes are used according to size.
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: error flag, qualified by `rsp_valid`.
- `mem_wr_en` out 1: memory write enable.
- `mem_rw_mode` out 2: BYTE=00, HALFWORD=01, WORD=10.
- `mem_addr` out DMEM_ADDR_WIDTH: memory byte address.
- `mem_w_data` out 32: memory write data.
- `mem_r_data` in 32: asynchronous memory read data, zero-extended by the memory.

## Operation
- FSM states are IDLE, ACCESS, SPLIT and RESP.
- **IDLE → ACCESS:** the request is valid, aligned, in range and has a legal funct3.
- **IDLE → SPLIT:** the request is misaligned, in range and `LSU_MISALIGNED_EN` is defined.
- **IDLE → RESP with error:** any of the following:
  - `req_addr + size - 1 >= 2**DMEM_ADDR_WIDTH`; the upper address bits must be zero and there is no wrap-around.
  - funct3 is 011, 110 or 111.
  - a store with funct3[2]=1.
  - a misaligned request with the macro undefined.
- Size is 1 byte for funct3[1:0]=00, 2 bytes for 01 and 4 bytes for 10.
- Alignment rule: a halfword needs addr[0]=0; a word needs addr[1:0]=00.
- **ACCESS:** one cycle.
  - `mem_rw_mode` is set to the size, `mem_addr` to `req_addr[DMEM_ADDR_WIDTH-1:0]`, and `mem_wr_en` equals the captured `req_we`.
  - A load captures `mem_r_data` at the end of the cycle.
  - Next state is RESP.
- **SPLIT:** one byte per cycle with k = 0..size-1.
  - `mem_rw_mode`=BYTE, `mem_addr`=addr+k, `mem_w_data`={24'b0, wdata[8k+7:8k]}.
  - A load writes `mem_r_data[7:0]` into buffer byte k (little-endian).
  - After k = size-1 the next state is RESP.
- **Load extension:**
  - LB sign-extends bit 7 and LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW passes all 32 bits.
- **RESP:** one cycle with `rsp_valid`=1, then IDLE; `req_ready` rises in the cycle after RESP.
- All request fields are captured at acceptance; later changes to the `req_*` inputs have no effect.
- `mem_wr_en` is 0 in every state other than ACCESS/SPLIT of a store.

## Timing
- **Reset values:**
  - `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_wr_en`, `mem_addr` and `mem_w_data` are 0.
  - `mem_rw_mode` is 00 and the state is IDLE, so `req_ready`=1 in the first cycle after reset deasserts.
- **Latency** is counted from the accept edge to the `rsp_valid` cycle:
  - aligned access: 2 cycles;
  - split access: size+1 cycles (3 for a halfword, 5 for a word);
  - error: 1 cycle with no memory access.
- **Throughput:**
  - aligned: one request per 3 cycles;
  - split: one request per size+2 cycles.
- **Reset mid-operation:** the FSM returns to IDLE and `mem_wr_en` drops the same edge. Bytes of a split store that were already written stay written; there is no rollback and no response is issued.
- A request presented while `req_ready`=0 is ignored; the requester holds `req_valid` until it is accepted.

## Configuration
- `LSU_MISALIGNED_EN`
  - **Defined:** misaligned halfword/word accesses go through SPLIT using byte accesses; `rsp_err`=0 if in range.
  - **Undefined:** misaligned accesses respond with `rsp_err`=1 after 1 cycle; the SPLIT state and byte buffer are not compiled.
- Aligned, range and funct3 behaviour is identical in both builds.

## Test plan
- **Aligned word:** SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → one `mem_wr_en` pulse with `mem_rw_mode`=10; the load returns `rsp_rdata`=0xDEADBEEF with `rsp_valid` 2 cycles after accept.
- **Extension:** SB 0x20 data 0x80, then LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080; LH 0x20 with memory 0x8000 → 0xFFFF8000.
- **Misaligned, macro defined:** SW 0x13 data 0x11223344 → byte writes 0x44/0x33/0x22/0x11 to 0x13..0x16 and `rsp_valid` 5 cycles after accept; LW 0x13 returns 0x11223344.
- **Misaligned, macro undefined:** LH 0x21 → `rsp_err`=1 and `rsp_rdata`=0 1 cycle after accept, with `mem_wr_en` never asserted.
- **Range and funct3 errors:** LW 0xFFE (DMEM_ADDR_WIDTH=12) → `rsp_err`=1; LW 0x1000 → `rsp_err`=1; SB with funct3=100 → `rsp_err`=1; no memory access in any case.
- **Reset mid-split:** assert `rst`=0 during the second byte of SW 0x13 → `mem_wr_en` drops at the same edge, no `rsp_valid`, `req_ready`=1 after release, and byte 0x13 holds 0x44.
